// File: rtl/ifetch.sv
// Instruction fetch: one outstanding memory request, result held for decode; instr_valid 1 cycle after mem_ack.
// stall holds the instruction in VALID, flush drops it; a missing ack past MAX_WAIT cycles parks the unit in ERR until rst.
module ifetch #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_addr,
  input  logic        flush,
  input  logic        stall,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [25:0] target_inst,
  output logic [31:0] seIn,
  output logic        pc_en,
  output logic        fetch_err
);

  typedef enum logic [2:0] {IDLE, REQ, VALID, DISCARD, ERR} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  wait_cnt;
  logic [31:0] addr_q;
  logic [31:0] instr_q;
  logic        load_addr;
  logic        load_instr;
  logic        timeout;

  // The cycle that would make MAX_WAIT unacknowledged cycles; an ack in that cycle still wins.
  assign timeout = !mem_ack && (wait_cnt == 8'(MAX_WAIT - 1));

  always_comb begin
    state_nxt  = state;
    load_addr  = 1'b0;
    load_instr = 1'b0;
    case (state)
      IDLE: begin
        load_addr = 1'b1;
        state_nxt = (pc_addr[1:0] != 2'b00) ? ERR : REQ;
      end
      REQ: begin
        if (mem_ack) begin
          if (!flush) begin
            load_instr = 1'b1;
            state_nxt  = VALID;
          end else begin
            state_nxt  = IDLE;
          end
        end else if (timeout) begin
          state_nxt = ERR;
        end else if (flush) begin
          state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_ack) begin
          state_nxt = IDLE;
        end else if (timeout) begin
          state_nxt = ERR;
        end
      end
      VALID: begin
        if (flush || !stall) begin
          state_nxt = IDLE;
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      instr_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        wait_cnt <= '0;
      end else if (state == REQ || state == DISCARD) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (load_addr) begin
        addr_q <= pc_addr;
      end
      if (load_instr) begin
        instr_q <= mem_rdata;
      end
    end
  end

  assign mem_req     = (state == REQ) || (state == DISCARD);
  assign mem_addr    = addr_q;
  assign instr       = instr_q;
  assign instr_valid = (state == VALID);
  assign pc_en       = (state == VALID) && !stall && !flush;
  assign fetch_err   = (state == ERR);
  assign target_inst = instr_q[25:0];
  assign seIn        = {{16{instr_q[15]}}, instr_q[15:0]};

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: drives PC/memory side transaction by transaction, scoreboard monitor checks what comes out.
module tb_ifetch;
  localparam int MAXW    = 4;
  localparam int K_NORM  = 0;
  localparam int K_FLREQ = 1;
  localparam int K_FLVAL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_addr = '0;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic [25:0] target_inst;
  logic [31:0] seIn;
  logic        pc_en;
  logic        fetch_err;

  ifetch #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .flush(flush), .stall(stall),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_addr(mem_addr),
    .instr(instr), .instr_valid(instr_valid), .target_inst(target_inst), .seIn(seIn),
    .pc_en(pc_en), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] req_q[$];
  logic [31:0] del_q[$];
  logic [31:0] last_data = '0;
  logic [31:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: event occurred with nothing expected", name);
  endtask

  function automatic logic [31:0] sext16(input logic [31:0] w);
    return 32'($signed(w[15:0]));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b1; flush = 1'b0; stall = 1'b0; mem_ack = 1'b0;
    repeat (cyc) step();
    rst = 1'b0;
    last_data = '0;
  endtask

  // Memory-side monitor: every accepted response and every held instruction is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && mem_ack) begin
        if (req_q.size() == 0) fail_now("unexpected_ack");
        else chk("mem_addr", mem_addr, req_q.pop_front());
      end
      if (instr_valid) begin
        if (del_q.size() == 0) begin
          fail_now("unexpected_valid");
        end else begin
          mon_e = del_q[0];
          chk("instr", instr, mon_e);
          chk("seIn", seIn, sext16(mon_e));
          chk("target_inst", 32'(target_inst), 32'(mon_e[25:0]));
          chk("pc_en", 32'(pc_en), 32'(!stall && !flush));
          if (flush || !stall) void'(del_q.pop_front());
        end
      end else begin
        chk("pc_en_not_valid", 32'(pc_en), 32'(0));
      end
    end
  end

  // One fetch starting in an IDLE cycle; ends in the following IDLE cycle.
  task automatic fetch(input int kind, input logic [31:0] addr, input logic [31:0] data,
                       input int lat, input int stl);
    int steps;
    int n;
    steps = 0;
    n = 0;
    pc_addr = addr; flush = 1'b0; mem_ack = 1'b0;
    stall = 1'($urandom_range(0, 1));
    while (!mem_req && n < 8) begin step(); n++; steps++; end
    chk("idle_cycles", 32'(n), 32'(1));
    if (mem_req) begin
      req_q.push_back(addr);
      pc_addr = $urandom;
      for (int c = 0; c <= lat; c++) begin
        chk("mem_req_held", 32'(mem_req), 32'(1));
        mem_ack   = (c == lat);
        mem_rdata = (c == lat) ? data : $urandom;
        flush     = (kind == K_FLREQ) ? ((c == 0) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
        step(); steps++;
      end
      mem_ack = 1'b0; flush = 1'b0;
      if (kind == K_FLREQ) begin
        chk("flushed_instr_kept", instr, last_data);
        chk("flushed_no_valid", 32'(instr_valid), 32'(0));
        chk("flushed_cycles", 32'(steps), 32'(lat + 2));
      end else begin
        del_q.push_back(data);
        last_data = data;
        chk("valid_after_ack", 32'(instr_valid), 32'(1));
        for (int s = 0; s < stl; s++) begin
          stall = 1'b1; flush = 1'b0;
          step(); steps++;
        end
        stall = (kind == K_FLVAL) ? 1'($urandom_range(0, 1)) : 1'b0;
        flush = (kind == K_FLVAL);
        step(); steps++;
        stall = 1'b0; flush = 1'b0;
        chk("fetch_cycles", 32'(steps), 32'(lat + stl + 3));
        chk("back_to_idle", 32'({instr_valid, mem_req}), 32'(0));
      end
    end
  endtask

  // No ack ever arrives; with_flush sends the request through DISCARD, which must keep counting.
  task automatic timeout_test(input logic with_flush);
    int n;
    n = 0;
    pc_addr = 32'h0000_1000; mem_ack = 1'b0; flush = 1'b0;
    step();
    chk("timeout_req_start", 32'(mem_req), 32'(1));
    while (mem_req && n < 20) begin
      flush = (n == 0) ? with_flush : 1'b0;
      step(); n++;
    end
    flush = 1'b0;
    chk("timeout_req_cycles", 32'(n), 32'(MAXW));
    chk("timeout_err", 32'(fetch_err), 32'(1));
    for (int i = 0; i < 5; i++) begin
      mem_ack = 1'($urandom_range(0, 1)); flush = 1'($urandom_range(0, 1));
      stall = 1'($urandom_range(0, 1)); pc_addr = $urandom;
      step();
      chk("err_sticky", 32'(fetch_err), 32'(1));
      chk("err_outputs", 32'({mem_req, instr_valid, pc_en}), 32'(0));
    end
    do_reset(1);
    chk("err_cleared_by_rst", 32'(fetch_err), 32'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int kind;
    int n;
    do_reset(2);
    chk("rst_mem_req", 32'(mem_req), 32'(0));
    chk("rst_mem_addr", mem_addr, 32'(0));
    chk("rst_instr", instr, 32'(0));
    chk("rst_flags", 32'({instr_valid, pc_en, fetch_err}), 32'(0));
    chk("rst_target_inst", 32'(target_inst), 32'(0));
    chk("rst_seIn", seIn, 32'(0));

    fetch(K_NORM, 32'h0040_0000, 32'h8C22_FFFC, 0, 0);
    chk("basic_seIn_const", seIn, 32'hFFFF_FFFC);
    chk("basic_target_const", 32'(target_inst), 32'h022_FFFC);
    fetch(K_NORM, 32'h0040_0004, 32'h8C22_FFFC, 0, 4);
    fetch(K_FLREQ, 32'h0040_0008, 32'h0800_0010, 3, 0);
    fetch(K_FLREQ, 32'h0040_000C, 32'h1234_8765, 0, 0);
    fetch(K_FLVAL, 32'h0040_0010, 32'h2408_7FFF, 1, 2);
    fetch(K_NORM, 32'h0040_0020, 32'hFFFF_0001, 3, 1);

    pc_addr = 32'h0040_0030;
    step();
    chk("midreq_req", 32'(mem_req), 32'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_data = '0;
    chk("midreq_rst_req", 32'(mem_req), 32'(0));
    chk("midreq_rst_addr", mem_addr, 32'(0));
    chk("midreq_rst_instr", instr, 32'(0));

    for (int t = 0; t < 80; t++) begin
      n = $urandom_range(0, 9);
      kind = (n < 6) ? K_NORM : ((n < 8) ? K_FLREQ : K_FLVAL);
      fetch(kind, {$urandom, 2'b00} & 32'hFFFF_FFFC, $urandom,
            $urandom_range(0, MAXW - 1), $urandom_range(0, 3));
    end

    timeout_test(1'b0);
    fetch(K_NORM, 32'h0040_0100, 32'h0C10_0040, 0, 0);
    timeout_test(1'b1);

    pc_addr = 32'h0040_0002;
    step();
    chk("misalign_err", 32'(fetch_err), 32'(1));
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_req) n++;
      step();
    end
    chk("misalign_no_req", 32'(n), 32'(0));
    do_reset(1);
    fetch(K_NORM, 32'h0040_0200, 32'h2002_8000, 1, 0);

    step();
    chk("req_q_drained", 32'(req_q.size()), 32'(0));
    chk("del_q_drained", 32'(del_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter MAX_WAIT, default 15, is the number of REQ/DISCARD cycles allowed without mem_ack before a fetch error; legal range is 1..255.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset. Port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 `rst`, input, 1: synchronous active-high reset.
REQ-004 `pc_addr`, input, 32: current instruction address from the program counter.
REQ-005 `flush`, input, 1: a taken jump or branch redirects the PC; in-flight or held instruction is dropped.
REQ-006 `stall`, input, 1: downstream stage cannot accept the held instruction this cycle.
REQ-007 `mem_ack`, input, 1: instruction memory returns data this cycle.
REQ-008 `mem_rdata`, input, 32: instruction word, sampled only when mem_ack=1.
REQ-009 `mem_req`, output, 1: fetch request, held high until acknowledged.
REQ-010 `mem_addr`, output, 32: registered fetch address, stable while mem_req=1.
REQ-011 `instr`, output, 32: held instruction word.
REQ-012 `instr_valid`, output, 1: instr is valid for downstream.
REQ-013 `target_inst`, output, 26: instr[25:0], jump target field to the PC.
REQ-014 `seIn`, output, 32: instr[15:0] sign-extended (bit 15 replicated into 31:16), to the PC.
REQ-015 `pc_en`, output, 1: PC advance strobe, combinational.
REQ-016 `fetch_err`, output, 1: sticky error flag.

Function
REQ-017 The FSM SHALL have the states IDLE, REQ, VALID, DISCARD and ERR.
REQ-018 IDLE: latch mem_addr<=pc_addr; if pc_addr[1:0]!=0, go to ERR; otherwise go to REQ. Lasts exactly one cycle.
REQ-019 REQ: mem_req=1; wait counter increments each cycle.
REQ-020 REQ with mem_ack=1 and flush=0: instr<=mem_rdata, go to VALID. instr_valid is therefore high the cycle after ack (1-cycle latency from ack).
REQ-021 REQ with flush=1 and mem_ack=0: go to DISCARD. REQ with flush=1 and mem_ack=1: drop the data and go to IDLE; instr is unchanged.
REQ-022 DISCARD: mem_req=1 and mem_addr is held. On mem_ack, drop the data and go to IDLE. flush is ignored in this state.
REQ-023 VALID: instr_valid=1.
  - flush=1: drop, go to IDLE, pc_en=0.
  - Else stall=0: pc_en=1 for this cycle, go to IDLE.
  - Else stall=1: hold; instr and outputs are stable.
REQ-024 pc_en SHALL equal (state==VALID & !stall & !flush) and be 0 in every other state.
REQ-025 The wait counter SHALL be 8 bits, cleared on entry to REQ, and kept counting in DISCARD. If it reaches MAX_WAIT with no ack, go to ERR.
REQ-026 ERR: mem_req=0, instr_valid=0, pc_en=0, fetch_err=1. Only rst exits ERR.
REQ-027 mem_req SHALL be 1 only in REQ and DISCARD, and SHALL never drop before mem_ack.
REQ-028 target_inst and seIn SHALL be combinational from instr.
REQ-029 Minimum throughput SHALL be one instruction per 3 cycles (IDLE, REQ with ack, VALID) with stall=0.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE and clear the wait counter. Outputs after reset: mem_req=0, mem_addr=0, instr=0, instr_valid=0, pc_en=0, fetch_err=0, target_inst=0, seIn=0.
REQ-031 rst SHALL take priority over every other input in every state, including mid-request and ERR.
REQ-032 The first IDLE cycle after rst deasserts SHALL latch pc_addr.

Verification
REQ-033 Basic fetch: rst 2 cycles; pc_addr=0x00400000; mem_ack in the first REQ cycle with mem_rdata=0x8C22FFFC; stall=0.
  - mem_addr=0x00400000.
  - instr_valid=1 next cycle with instr=0x8C22FFFC, seIn=0xFFFFFFFC, target_inst=0x022FFFC.
  - pc_en=1 in that same cycle.
REQ-034 Stall hold: same fetch with stall=1 for 4 cycles. instr_valid stays 1, instr is stable, pc_en=0. pc_en pulses once in the cycle stall falls.
REQ-035 Flush in flight: flush=1 during REQ; mem_ack 3 cycles later with 0x08000010.
  - mem_req stays high until ack.
  - instr_valid is never 1 and instr keeps its old value.
  - Next fetch uses the new pc_addr.
REQ-036 Simultaneous flush and ack in REQ: data dropped, IDLE next cycle, pc_en=0.
REQ-037 Timeout: MAX_WAIT=4, mem_ack held 0. After 4 REQ cycles: fetch_err=1, mem_req=0. fetch_err stays 1 until rst, after which a normal fetch succeeds.
REQ-038 Misaligned address: pc_addr=0x00400002 gives ERR after IDLE and mem_req is never asserted.
